// File: rtl/l1_tx_if.sv
// l1_tx_if -- bundle of the l1_tx load, control, consumer and status signals.
//
// Optional feature macro: L1_TX_STALL_CNT_EN adds the stall_cnt status word.
//
// Signals (direction as seen by the l1_tx block, modport slave):
//   tx_done            in   frame abort/clear shared with the downstream layer
//   ld_wr, ld_addr     in   pixel load strobe and row-major address (0..195)
//   ld_din_0/1         in   signed 18-bit pixel for channel 0/1
//   go                 in   start-of-frame pulse
//   bsy_in             in   downstream busy
//   strt               out  window start pulse towards the consumer
//   din_0/1            out  registered tap data, channel 0/1
//   busy, done         out  streaming in progress / frame complete
//   stall_cnt          out  cycles spent waiting on bsy_in (macro only)
// The master modport is the driving side (producer of the controls).
interface l1_tx_if;
    logic               tx_done;
    logic               ld_wr;
    logic [7:0]         ld_addr;
    logic signed [17:0] ld_din_0;
    logic signed [17:0] ld_din_1;
    logic               go;
    logic               bsy_in;
    logic               strt;
    logic signed [17:0] din_0;
    logic signed [17:0] din_1;
    logic               busy;
    logic               done;
`ifdef L1_TX_STALL_CNT_EN
    logic [15:0]        stall_cnt;

    modport master (
        output tx_done, ld_wr, ld_addr, ld_din_0, ld_din_1, go, bsy_in,
        input  strt, din_0, din_1, busy, done, stall_cnt
    );
    modport slave (
        input  tx_done, ld_wr, ld_addr, ld_din_0, ld_din_1, go, bsy_in,
        output strt, din_0, din_1, busy, done, stall_cnt
    );
`else
    modport master (
        output tx_done, ld_wr, ld_addr, ld_din_0, ld_din_1, go, bsy_in,
        input  strt, din_0, din_1, busy, done
    );
    modport slave (
        input  tx_done, ld_wr, ld_addr, ld_din_0, ld_din_1, go, bsy_in,
        output strt, din_0, din_1, busy, done
    );
`endif
endinterface

// File: rtl/l1_tx.sv
// l1_tx -- streams 3x3 windows of a two-channel 14x14 pixel map to a
// downstream conv layer. Two 196x18 RAMs hold the map; for each of the
// 144 output positions (12x12, row-major) the nine taps are read on
// consecutive cycles and presented on din_0/din_1 one cycle after issue.
//
// Optional feature macro: L1_TX_STALL_CNT_EN -- adds a saturating 16-bit
// count of cycles spent in ISSUE/GAP with bsy_in high (bus.stall_cnt).
//
// Ports:
//   clk   in  sole clock, rising edge
//   rst   in  synchronous active-high reset
//   bus   l1_tx_if.slave: load port, go/tx_done control, bsy_in/strt/din
//         consumer handshake, busy/done status
module l1_tx (
    input  logic    clk,
    input  logic    rst,
    l1_tx_if.slave  bus
);
    localparam logic [7:0] N_PIX    = 8'd196;
    localparam logic [3:0] LAST_POS = 4'd11;
    localparam logic [3:0] LAST_TAP = 4'd8;

    typedef enum logic [2:0] {IDLE, ISSUE, STREAM, GAP, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         row_q, row_d;
    logic [3:0]         col_q, col_d;
    logic [3:0]         tap_q, tap_d;
    logic signed [17:0] din0_q, din1_q;
    logic signed [17:0] ram0 [0:195];
    logic signed [17:0] ram1 [0:195];

    logic               strt_c;
    logic               rd_en;
    logic               wr_en;
    logic               idle_like;
    logic [7:0]         base;
    logic [7:0]         tap_off;
    logic [7:0]         rd_addr;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);

    // Window origin and tap offset (ki*14 + kj); max address 165+30 = 195.
    assign base = ({4'd0, row_q} * 8'd14) + {4'd0, col_q};

    always_comb begin
        tap_off = 8'd0;
        case (tap_q)
            4'd0:    tap_off = 8'd0;
            4'd1:    tap_off = 8'd1;
            4'd2:    tap_off = 8'd2;
            4'd3:    tap_off = 8'd14;
            4'd4:    tap_off = 8'd15;
            4'd5:    tap_off = 8'd16;
            4'd6:    tap_off = 8'd28;
            4'd7:    tap_off = 8'd29;
            4'd8:    tap_off = 8'd30;
            default: tap_off = 8'd0;
        endcase
    end

    assign rd_addr = base + tap_off;

    // Loads are only accepted while no frame is being streamed.
    assign wr_en = bus.ld_wr && (bus.ld_addr < N_PIX) && idle_like;

    // GAP is a single hold cycle; the wait on bsy_in is done in ISSUE, so a
    // consumer that is busy for 10 cycles after strt sees strt every 11.
    // RAM reads happen only when a tap is actually issued, so din holds the
    // last tap for as long as ISSUE is stalled.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        tap_d   = tap_q;
        strt_c  = 1'b0;
        rd_en   = 1'b0;
        if (bus.tx_done) begin
            state_d = IDLE;
            row_d   = 4'd0;
            col_d   = 4'd0;
            tap_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.go) begin
                        state_d = ISSUE;
                        row_d   = 4'd0;
                        col_d   = 4'd0;
                        tap_d   = 4'd0;
                    end
                end
                ISSUE: begin
                    if (!bus.bsy_in) begin
                        strt_c  = 1'b1;
                        rd_en   = 1'b1;
                        tap_d   = 4'd1;
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    rd_en = 1'b1;
                    if (tap_q == LAST_TAP) begin
                        tap_d   = 4'd0;
                        state_d = GAP;
                    end else begin
                        tap_d = tap_q + 4'd1;
                    end
                end
                GAP: begin
                    if (col_q == LAST_POS) begin
                        if (row_q == LAST_POS) begin
                            state_d = DONE;
                        end else begin
                            col_d   = 4'd0;
                            row_d   = row_q + 4'd1;
                            state_d = ISSUE;
                        end
                    end else begin
                        col_d   = col_q + 4'd1;
                        state_d = ISSUE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            tap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tap_q   <= tap_d;
        end
    end

    // Pixel RAMs: not reset, written only between frames.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram0[bus.ld_addr] <= bus.ld_din_0;
            ram1[bus.ld_addr] <= bus.ld_din_1;
        end
    end

    // Registered read port doubles as the din output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            din0_q <= '0;
            din1_q <= '0;
        end else if (rd_en) begin
            din0_q <= ram0[rd_addr];
            din1_q <= ram1[rd_addr];
        end
    end

    // strt is masked by rst so a reset landing on an ISSUE cycle emits nothing.
    assign bus.strt  = strt_c & ~rst;
    assign bus.din_0 = din0_q;
    assign bus.din_1 = din1_q;
    assign bus.busy  = (state_q == ISSUE) || (state_q == STREAM) || (state_q == GAP);
    assign bus.done  = (state_q == DONE);

`ifdef L1_TX_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic        go_acc;

    assign go_acc = bus.go && idle_like;

    always_comb begin
        stall_d = stall_q;
        if (bus.tx_done || go_acc) begin
            stall_d = 16'd0;
        end else if (((state_q == ISSUE) || (state_q == GAP)) && bus.bsy_in
                     && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_l1_tx.sv
// tb_l1_tx -- directed bench for l1_tx. Inputs are driven at the falling
// edge and outputs sampled 1 ns later. The downstream consumer is modelled
// as busy for the 10 cycles following each strt.
module tb_l1_tx;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    l1_tx_if bus ();

    l1_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offset of tap k inside a 3x3 window of a 14-wide map.
    function automatic int tap_off(input int k);
        return (k / 3) * 14 + (k % 3);
    endfunction

    // Runs one frame starting with a go pulse. Window indices select where
    // to insert a 20-cycle extra stall, a load attempt, a tx_done abort
    // (mid-STREAM, tap 4) or a reset (GAP cycle); -1 disables each.
    task automatic run_frame(input string name, input int stall_win, input int wr_win,
                             input int abort_win, input int rst_win);
        int n_strt, last_t, pend_k, cur_base, hold_exp, bsy_cnt, p, exp_v, sc_prev;
        bit hold_ok, stop, abort_next, rst_next;
        n_strt = 0; last_t = -1; pend_k = -1; cur_base = 0; hold_exp = 0;
        bsy_cnt = 0; sc_prev = 0; hold_ok = 0; stop = 0; abort_next = 0; rst_next = 0;
        for (int t = 0; t < 4000 && !stop; t++) begin
            @(negedge clk);
            rst         = 1'b0;
            bus.go      = (t == 0);
            bus.bsy_in  = (bsy_cnt != 0);
            bus.tx_done = 1'b0;
            bus.ld_wr   = 1'b0;
            if (pend_k == 4 && n_strt - 1 == wr_win) begin
                bus.ld_wr    = 1'b1;
                bus.ld_addr  = 8'd15;
                bus.ld_din_0 = 18'sd777;
                bus.ld_din_1 = -18'sd777;
            end
            if (pend_k == 4 && n_strt - 1 == abort_win) bus.tx_done = 1'b1;
            if (pend_k == 8 && n_strt - 1 == rst_win) rst = 1'b1;
            #1;
            if (abort_next) begin
                check("abort_strt", bus.strt, 0);
                check("abort_busy", bus.busy, 0);
                check("abort_done", bus.done, 0);
`ifdef L1_TX_STALL_CNT_EN
                check("abort_stall_cnt", bus.stall_cnt, 0);
`endif
                $display("[TB] %s aborted at window %0d base %0d", name, n_strt - 1, cur_base);
                stop = 1;
            end else if (rst_next) begin
                check("rst_strt", bus.strt, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_din_0", bus.din_0, 0);
                check("rst_din_1", bus.din_1, 0);
                $display("[TB] %s reset in GAP of window %0d", name, n_strt - 1);
                stop = 1;
            end else begin
                check("strt_vs_bsy", bus.strt & bus.bsy_in, 0);
                if (pend_k >= 0) begin
                    exp_v = cur_base + tap_off(pend_k);
                    check("din_0", bus.din_0, exp_v);
                    check("din_1", bus.din_1, -exp_v);
                    if (pend_k == 8) begin
                        hold_exp = exp_v;
                        hold_ok  = 1;
                        pend_k   = -1;
                        $display("[TB] %s window %0d base %0d taps checked", name, n_strt - 1, cur_base);
                    end else begin
                        pend_k++;
                    end
                end else if (hold_ok) begin
                    check("din_0_hold", bus.din_0, hold_exp);
                    check("din_1_hold", bus.din_1, -hold_exp);
                end
                if (bus.tx_done) abort_next = 1;
                if (rst) rst_next = 1;
                if (bsy_cnt != 0) bsy_cnt--;
                if (bus.strt) begin
                    p = n_strt;
                    check("busy_at_strt", bus.busy, 1);
                    check("done_at_strt", bus.done, 0);
                    if (p == 0) check("first_strt_t", t, 1);
                    else check("strt_period", t - last_t, (p - 1 == stall_win) ? 31 : 11);
`ifdef L1_TX_STALL_CNT_EN
                    if (p == 0) check("stall_cnt_start", bus.stall_cnt, 0);
                    else if (p - 1 == stall_win) check("stall_cnt_stall", bus.stall_cnt - sc_prev, 22);
                    else if (p == 1) check("stall_cnt_nominal", bus.stall_cnt - sc_prev, 2);
                    sc_prev = bus.stall_cnt;
`endif
                    last_t   = t;
                    cur_base = (p / 12) * 14 + (p % 12);
                    pend_k   = 0;
                    n_strt++;
                    bsy_cnt  = (p == stall_win) ? 30 : 10;
                end
                if (n_strt == 144 && pend_k < 0 && bus.done) stop = 1;
            end
        end
        if (!stop) check("frame_timeout", 0, 1);
        if (abort_win < 0 && rst_win < 0) begin
            check("strt_count", n_strt, 144);
            check("last_base", cur_base, 165);
            check("done_end", bus.done, 1);
            check("busy_end", bus.busy, 0);
        end
        $display("[TB] frame %s: %0d strt pulses", name, n_strt);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst          = 1'b1;
        bus.tx_done  = 1'b0;
        bus.ld_wr    = 1'b0;
        bus.ld_addr  = 8'd0;
        bus.ld_din_0 = 18'sd0;
        bus.ld_din_1 = 18'sd0;
        bus.go       = 1'b0;
        bus.bsy_in   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_strt", bus.strt, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_din_0", bus.din_0, 0);
        check("reset_din_1", bus.din_1, 0);
        $display("[TB] reset checked");

        // Load ch0[a]=a, ch1[a]=-a, then an out-of-range write
        for (int a = 0; a < 196; a++) begin
            @(negedge clk);
            rst          = 1'b0;
            bus.ld_wr    = 1'b1;
            bus.ld_addr  = 8'(a);
            bus.ld_din_0 = 18'(a);
            bus.ld_din_1 = 18'(-a);
        end
        @(negedge clk);
        bus.ld_addr  = 8'd200;
        bus.ld_din_0 = 18'sd999;
        bus.ld_din_1 = 18'sd999;
        @(negedge clk);
        bus.ld_wr = 1'b0;
        $display("[TB] map loaded");

        // go and tx_done together in IDLE: go is ignored
        bus.go      = 1'b1;
        bus.tx_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.go      = 1'b0;
            bus.tx_done = 1'b0;
            #1;
            check("go_txdone_strt", bus.strt, 0);
            check("go_txdone_busy", bus.busy, 0);
        end
        $display("[TB] go+tx_done in IDLE checked");

        // Full frame with a 20-cycle extra stall after window 5
        run_frame("A", 5, -1, -1, -1);
        // Restart from DONE, load attempt while streaming, abort at (3,5)
        run_frame("B", -1, 2, 41, -1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("idle_busy", bus.busy, 0);
            check("idle_done", bus.done, 0);
        end
        // Clean frame: base 0 restart, map must be intact
        run_frame("C", -1, -1, -1, -1);
        // Reset during GAP of the first window
        run_frame("D", -1, -1, -1, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
